// File: rtl/voter_pkg.sv
// Shared constants for the four-seat vote decision unit.
package voter_pkg;

  typedef logic [2:0] verdict_t;

  localparam verdict_t VERDICT_WIN  = 3'b100;
  localparam verdict_t VERDICT_TIE  = 3'b010;
  localparam verdict_t VERDICT_FAIL = 3'b001;
  localparam verdict_t VERDICT_NONE = 3'b000;

  localparam int N_VOTERS   = 4;
  localparam int WIN_THRESH = 3;

  // Map a yes count onto the one-hot verdict encoding.
  function automatic verdict_t count_to_verdict(input logic [2:0] cnt);
    if (cnt >= 3'(WIN_THRESH)) begin
      return VERDICT_WIN;
    end else if (cnt == 3'd2) begin
      return VERDICT_TIE;
    end else begin
      return VERDICT_FAIL;
    end
  endfunction

endpackage

// File: rtl/voter_decode.sv
// Combinational ballot decoder: yes-vote popcount plus one-hot verdict.
module voter_decode
  import voter_pkg::*;
(
  input  logic [N_VOTERS-1:0] ballot_i,
  output logic [2:0]          yes_cnt_o,
  output logic [3:1]          verdict_o
);

  // Count yes votes 3 bits wide so that four yes votes cannot overflow.
  always_comb begin
    yes_cnt_o = 3'd0;
    for (int k = 0; k < N_VOTERS; k++) begin
      yes_cnt_o = yes_cnt_o + {2'b00, ballot_i[k]};
    end
  end

  assign verdict_o = count_to_verdict(yes_cnt_o);

endmodule

// File: rtl/voter_if_reg.sv
// Registered vote decision stage with saturating per-verdict tallies.
// Every output comes straight from a flop; there is no input-to-output path.
module voter_if_reg
  import voter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       I,
  input  logic             i_valid,
  output logic [3:1]       O,
  output logic             o_valid,
  output logic [2:0]       yes_cnt,
  output logic [CNT_W-1:0] win_tally,
  output logic [CNT_W-1:0] tie_tally,
  output logic [CNT_W-1:0] fail_tally
);

  logic [2:0] yes_cnt_d;
  logic [3:1] verdict_d;

  logic [3:1] verdict_q;
  logic       valid_q;
  logic [2:0] yes_cnt_q;

  voter_decode u_decode (
    .ballot_i  (I),
    .yes_cnt_o (yes_cnt_d),
    .verdict_o (verdict_d)
  );

  // Capture the verdict of each accepted ballot; hold it while the input is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      verdict_q <= VERDICT_NONE;
      valid_q   <= 1'b0;
      yes_cnt_q <= 3'd0;
    end else begin
      valid_q <= i_valid;
      if (i_valid) begin
        verdict_q <= verdict_d;
        yes_cnt_q <= yes_cnt_d;
      end
    end
  end

  // Tally index gi follows verdict bit gi+1: 0 = fail, 1 = tie, 2 = win.
  for (genvar gi = 0; gi < 3; gi++) begin : g_tally
    logic [CNT_W-1:0] tally_q;

    // Saturating count of accepted ballots that produced this verdict.
    always_ff @(posedge clk) begin
      if (rst) begin
        tally_q <= '0;
      end else if (i_valid && verdict_d[gi+1] && (tally_q != {CNT_W{1'b1}})) begin
        tally_q <= tally_q + 1'b1;
      end
    end
  end

  assign O          = verdict_q;
  assign o_valid    = valid_q;
  assign yes_cnt    = yes_cnt_q;
  assign fail_tally = g_tally[0].tally_q;
  assign tie_tally  = g_tally[1].tally_q;
  assign win_tally  = g_tally[2].tally_q;

endmodule

// File: tb/tb_voter_if_reg.sv
// Directed and random checks for voter_if_reg, with a second small-tally instance.
module tb_voter_if_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] I;
  logic       i_valid;
  logic [3:1] O;
  logic       o_valid;
  logic [2:0] yes_cnt;
  logic [7:0] win_tally, tie_tally, fail_tally;

  logic       rst2;
  logic [3:0] I2;
  logic       i_valid2;
  logic [3:1] O2;
  logic       o_valid2;
  logic [2:0] yes_cnt2;
  logic [1:0] win2, tie2, fail2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  voter_if_reg #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .I(I), .i_valid(i_valid),
    .O(O), .o_valid(o_valid), .yes_cnt(yes_cnt),
    .win_tally(win_tally), .tie_tally(tie_tally), .fail_tally(fail_tally)
  );

  voter_if_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst2), .I(I2), .i_valid(i_valid2),
    .O(O2), .o_valid(o_valid2), .yes_cnt(yes_cnt2),
    .win_tally(win2), .tie_tally(tie2), .fail_tally(fail2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed verdicts and yes counts for ballots 0000..1111.
  logic [2:0] sweep_verdict [16];
  logic [2:0] sweep_yes     [16];

  int exp_win, exp_tie, exp_fail, accepted;
  logic [2:0] exp_o, exp_yes;
  logic       exp_v;

  initial begin
    sweep_verdict = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010, 3'b010, 3'b100,
                      3'b001, 3'b010, 3'b010, 3'b100, 3'b010, 3'b100, 3'b100, 3'b100};
    sweep_yes     = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
                      3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4};

    rst = 1'b1; I = 4'b1111; i_valid = 1'b1;
    rst2 = 1'b1; I2 = 4'b0000; i_valid2 = 1'b0;

    // Reset held for two cycles while a valid ballot is presented.
    for (int c = 0; c < 2; c++) begin
      tick();
      $display("reset cycle %0d: O=%b o_valid=%b yes=%0d", c, O, o_valid, yes_cnt);
      check_eq("rst_O", 32'(O), 32'd0);
      check_eq("rst_valid", 32'(o_valid), 32'd0);
      check_eq("rst_yes", 32'(yes_cnt), 32'd0);
      check_eq("rst_win", 32'(win_tally), 32'd0);
      check_eq("rst_tie", 32'(tie_tally), 32'd0);
      check_eq("rst_fail", 32'(fail_tally), 32'd0);
    end

    // Sweep all sixteen ballots back to back.
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      I = 4'(k);
      i_valid = 1'b1;
      tick();
      $display("ballot %b -> O=%b yes=%0d o_valid=%b", I, O, yes_cnt, o_valid);
      check_eq($sformatf("sweep_O_%0d", k), 32'(O), 32'(sweep_verdict[k]));
      check_eq($sformatf("sweep_yes_%0d", k), 32'(yes_cnt), 32'(sweep_yes[k]));
      check_eq($sformatf("sweep_valid_%0d", k), 32'(o_valid), 32'd1);
    end
    check_eq("sweep_fail_tally", 32'(fail_tally), 32'd5);
    check_eq("sweep_tie_tally", 32'(tie_tally), 32'd6);
    check_eq("sweep_win_tally", 32'(win_tally), 32'd5);

    // Tie ballot followed by an idle cycle: verdict holds, valid drops.
    I = 4'b1100; i_valid = 1'b1;
    tick();
    $display("ballot %b -> O=%b yes=%0d o_valid=%b", I, O, yes_cnt, o_valid);
    check_eq("hold_tie_O", 32'(O), 32'b010);
    check_eq("hold_tie_valid", 32'(o_valid), 32'd1);
    I = 4'b1111; i_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      $display("idle %0d -> O=%b yes=%0d o_valid=%b", c, O, yes_cnt, o_valid);
      check_eq("hold_O", 32'(O), 32'b010);
      check_eq("hold_yes", 32'(yes_cnt), 32'd2);
      check_eq("hold_valid", 32'(o_valid), 32'd0);
      check_eq("hold_fail", 32'(fail_tally), 32'd5);
      check_eq("hold_tie", 32'(tie_tally), 32'd7);
      check_eq("hold_win", 32'(win_tally), 32'd5);
    end

    // Two-bit tallies saturate at 3.
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0; I2 = 4'b1111; i_valid2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      $display("sat ballot %0d -> win=%0d tie=%0d fail=%0d", k, win2, tie2, fail2);
      check_eq($sformatf("sat_win_%0d", k), 32'(win2), (k > 3) ? 32'd3 : 32'(k));
    end
    check_eq("sat_tie", 32'(tie2), 32'd0);
    check_eq("sat_fail", 32'(fail2), 32'd0);
    check_eq("sat_O", 32'(O2), 32'b100);
    i_valid2 = 1'b0;

    // Reset coinciding with a valid win ballot after prior traffic.
    rst = 1'b1; I = 4'b0111; i_valid = 1'b1;
    tick();
    $display("reset with ballot %b -> O=%b yes=%0d o_valid=%b", I, O, yes_cnt, o_valid);
    check_eq("rst2_O", 32'(O), 32'd0);
    check_eq("rst2_valid", 32'(o_valid), 32'd0);
    check_eq("rst2_yes", 32'(yes_cnt), 32'd0);
    check_eq("rst2_win", 32'(win_tally), 32'd0);
    check_eq("rst2_tie", 32'(tie_tally), 32'd0);
    check_eq("rst2_fail", 32'(fail_tally), 32'd0);
    rst = 1'b0; i_valid = 1'b0;
    tick();
    check_eq("post_rst_O", 32'(O), 32'd0);
    check_eq("post_rst_win", 32'(win_tally), 32'd0);

    // Random traffic against a reference model.
    exp_win = 0; exp_tie = 0; exp_fail = 0; accepted = 0;
    exp_o = 3'b000; exp_yes = 3'd0; exp_v = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      I = 4'($urandom_range(0, 15));
      i_valid = 1'($urandom_range(0, 1));
      exp_v = i_valid;
      if (i_valid) begin
        accepted++;
        exp_yes = 3'($countones(I));
        if (exp_yes >= 3'd3) begin
          exp_o = 3'b100;
          if (exp_win < 255) exp_win++;
        end else if (exp_yes == 3'd2) begin
          exp_o = 3'b010;
          if (exp_tie < 255) exp_tie++;
        end else begin
          exp_o = 3'b001;
          if (exp_fail < 255) exp_fail++;
        end
      end
      tick();
      $display("rnd %0d: I=%b v=%b -> O=%b yes=%0d o_valid=%b", c, I, i_valid, O, yes_cnt, o_valid);
      check_eq("rnd_O", 32'(O), 32'(exp_o));
      check_eq("rnd_yes", 32'(yes_cnt), 32'(exp_yes));
      check_eq("rnd_valid", 32'(o_valid), 32'(exp_v));
      if (accepted > 0) begin
        check_eq("rnd_onehot", 32'($countones(O)), 32'd1);
      end
    end
    check_eq("rnd_win", 32'(win_tally), 32'(exp_win));
    check_eq("rnd_tie", 32'(tie_tally), 32'(exp_tie));
    check_eq("rnd_fail", 32'(fail_tally), 32'(exp_fail));
    check_eq("rnd_sum", 32'(win_tally) + 32'(tie_tally) + 32'(fail_tally), 32'(accepted));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
